// File: rtl/mc_audio_delay.sv
// Multi-channel audio delay line with a shared single-port sample RAM.
// A frame runs one RD/WAIT/WR triple per channel and then a DONE cycle that
// presents every channel of audio_out together. Output is wet, dry or a
// saturated dry+wet mix.
module mc_audio_delay #(
    parameter int unsigned NUM_CHANNELS = 3,
    parameter int unsigned SAMPLE_WIDTH = 16,
    parameter int unsigned MAX_DELAY    = 1024,
    localparam int unsigned DW          = $clog2(MAX_DELAY)
) (
    input  logic                                 audio_clk,
    input  logic                                 rst_in,
    input  logic                                 audio_trigger,
    input  logic                                 enable_delay,
    input  logic [1:0]                           mix_mode,
    input  logic [NUM_CHANNELS*DW-1:0]           delay_length,
    input  logic [NUM_CHANNELS*SAMPLE_WIDTH-1:0] audio_in,
    output logic [NUM_CHANNELS*SAMPLE_WIDTH-1:0] audio_out,
    output logic                                 data_valid_out,
    output logic                                 busy,
    output logic                                 trigger_dropped,
    output logic                                 saturated
);

    localparam int unsigned CW    = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam int unsigned AW    = CW + DW;
    localparam int unsigned WORDS = NUM_CHANNELS * MAX_DELAY;
    localparam int unsigned SW    = SAMPLE_WIDTH;

    localparam logic [SW-1:0] SMAX     = {1'b0, {(SW-1){1'b1}}};
    localparam logic [SW-1:0] SMIN     = {1'b1, {(SW-1){1'b0}}};
    localparam logic [DW-1:0] DMAX     = DW'(MAX_DELAY - 1);
    localparam logic [DW:0]   FILL_MAX = (DW+1)'(MAX_DELAY);
    localparam logic [CW-1:0] LAST_CH  = CW'(NUM_CHANNELS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StRd,
        StWait,
        StWr,
        StDone
    } state_e;

    state_e state_q, state_d;

    // Frame registers: the frame works only from these once captured.
    logic [SW-1:0]   cap_x_q [NUM_CHANNELS];
    logic [DW-1:0]   cap_d_q [NUM_CHANNELS];
    logic [1:0]      cap_mode_q;
    logic            cap_en_q;
    logic            prev_en_q;

    logic [CW-1:0]   ch_q;
    logic [DW-1:0]   wr_ptr_q;
    logic [DW:0]     fill_q;
    logic [SW-1:0]   res_q [NUM_CHANNELS];
    logic            sat_q;
    logic            drop_q;
    logic [NUM_CHANNELS*SW-1:0] out_q;

    // Unpacked, clamped views of the live inputs.
    logic [SW-1:0]   in_x [NUM_CHANNELS];
    logic [DW-1:0]   in_d [NUM_CHANNELS];
    logic [DW-1:0]   raw_d;

    // Current-channel datapath.
    logic [SW-1:0]   dry;
    logic [SW-1:0]   wet;
    logic [DW-1:0]   cur_d;
    logic [SW:0]     sum;
    logic            clip;
    logic            clip_hit;
    logic [SW-1:0]   cur_out;
    logic            last_ch;
    logic            start;
    logic [NUM_CHANNELS*SW-1:0] next_out;

    // Sample RAM.
    logic [SW-1:0]   mem [WORDS];
    logic [SW-1:0]   ram_rdata;
    logic [AW-1:0]   ram_addr;
    logic [DW-1:0]   rd_ptr;
    logic            ram_re;
    logic            ram_we;

    assign start   = (state_q == StIdle) && audio_trigger;
    assign last_ch = (ch_q == LAST_CH);

    // Split packed input buses per channel and clamp each delay to the buffer depth.
    always_comb begin
        raw_d = '0;
        for (int k = 0; k < NUM_CHANNELS; k++) begin
            in_x[k] = audio_in[k*SW +: SW];
            raw_d   = delay_length[k*DW +: DW];
            in_d[k] = (raw_d >= DMAX) ? DMAX : raw_d;
        end
    end

    // FSM state register.
    always_ff @(posedge audio_clk or posedge rst_in) begin
        if (rst_in) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: one RD/WAIT/WR triple per channel, then DONE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: if (audio_trigger) state_d = StRd;
            StRd:   state_d = StWait;
            StWait: state_d = StWr;
            StWr:   state_d = last_ch ? StDone : StRd;
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    assign busy           = (state_q != StIdle);
    assign data_valid_out = (state_q == StDone);
    assign trigger_dropped = drop_q;
    assign saturated      = sat_q;
    assign audio_out      = out_q;

    // Wet/dry selection and saturating mix for the channel being processed.
    always_comb begin
        dry      = cap_x_q[ch_q];
        cur_d    = cap_d_q[ch_q];
        wet      = '0;
        sum      = '0;
        clip     = 1'b0;
        clip_hit = 1'b0;
        cur_out  = '0;
        // Zero delay bypasses the RAM; an unfilled buffer yields silence.
        if (cur_d == '0) begin
            wet = dry;
        end else if (fill_q < {1'b0, cur_d}) begin
            wet = '0;
        end else begin
            wet = ram_rdata;
        end
        sum  = {dry[SW-1], dry} + {wet[SW-1], wet};
        clip = (sum[SW] != sum[SW-1]);
        case (cap_mode_q)
            2'd1: cur_out = clip ? (sum[SW] ? SMIN : SMAX) : sum[SW-1:0];
            2'd2: cur_out = dry;
            default: cur_out = wet;
        endcase
        if (!cap_en_q) begin
            cur_out = dry;
        end
        clip_hit = cap_en_q && (cap_mode_q == 2'd1) && clip;
    end

    // Assemble the full output word: finished channels plus the one in flight.
    always_comb begin
        next_out = '0;
        for (int k = 0; k < NUM_CHANNELS; k++) begin
            next_out[k*SW +: SW] = (k == int'(ch_q)) ? cur_out : res_q[k];
        end
    end

    // RAM port control: reads in RD, writes in WR, only while the delay is active.
    always_comb begin
        rd_ptr   = wr_ptr_q - cur_d;
        ram_re   = (state_q == StRd) && cap_en_q && (cur_d != '0);
        ram_we   = (state_q == StWr) && cap_en_q;
        ram_addr = (state_q == StWr) ? {ch_q, wr_ptr_q} : {ch_q, rd_ptr};
    end

    // Single-port synchronous sample RAM with registered read data.
    always_ff @(posedge audio_clk) begin
        if (ram_we) begin
            mem[ram_addr] <= dry;
        end
        if (ram_re) begin
            ram_rdata <= mem[ram_addr];
        end
    end

    // Frame capture, per-channel results, pointer/fill bookkeeping and flags.
    always_ff @(posedge audio_clk or posedge rst_in) begin
        if (rst_in) begin
            for (int k = 0; k < NUM_CHANNELS; k++) begin
                cap_x_q[k] <= '0;
                cap_d_q[k] <= '0;
                res_q[k]   <= '0;
            end
            cap_mode_q <= '0;
            cap_en_q   <= 1'b0;
            prev_en_q  <= 1'b0;
            ch_q       <= '0;
            wr_ptr_q   <= '0;
            fill_q     <= '0;
            sat_q      <= 1'b0;
            drop_q     <= 1'b0;
            out_q      <= '0;
        end else begin
            drop_q <= audio_trigger && busy;
            if (start) begin
                for (int k = 0; k < NUM_CHANNELS; k++) begin
                    cap_x_q[k] <= in_x[k];
                    cap_d_q[k] <= in_d[k];
                end
                cap_mode_q <= mix_mode;
                cap_en_q   <= enable_delay;
                prev_en_q  <= enable_delay;
                ch_q       <= '0;
                // Re-enabling the delay restarts the fill count so stale data stays hidden.
                if (enable_delay && !prev_en_q) begin
                    fill_q <= '0;
                end
            end
            if (state_q == StWr) begin
                res_q[ch_q] <= cur_out;
                if (clip_hit) begin
                    sat_q <= 1'b1;
                end
                if (last_ch) begin
                    out_q <= next_out;
                end else begin
                    ch_q <= ch_q + 1'b1;
                end
            end
            if ((state_q == StDone) && cap_en_q) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
                if (fill_q < FILL_MAX) begin
                    fill_q <= fill_q + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mc_audio_delay.sv
// Scoreboard bench for mc_audio_delay: the driver pushes expected frames from a
// frame-level reference model; a monitor pops and compares on every valid pulse.
module tb_mc_audio_delay;

    localparam int N  = 3;
    localparam int SW = 16;
    localparam int MD = 16;
    localparam int DW = 4;
    localparam int LAT = 3 * N + 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              trig = 1'b0;
    logic              en = 1'b0;
    logic [1:0]        mode = 2'd0;
    logic [N*DW-1:0]   dl = '0;
    logic [N*SW-1:0]   ain = '0;
    logic [N*SW-1:0]   aout;
    logic              dv;
    logic              bsy;
    logic              drp;
    logic              sat;

    mc_audio_delay #(
        .NUM_CHANNELS (N),
        .SAMPLE_WIDTH (SW),
        .MAX_DELAY    (MD)
    ) dut (
        .audio_clk       (clk),
        .rst_in          (rst),
        .audio_trigger   (trig),
        .enable_delay    (en),
        .mix_mode        (mode),
        .delay_length    (dl),
        .audio_in        (ain),
        .audio_out       (aout),
        .data_valid_out  (dv),
        .busy            (bsy),
        .trigger_dropped (drp),
        .saturated       (sat)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;
    int drop_cnt = 0;

    typedef struct {
        logic [N*SW-1:0] y;
        int              tc;
        bit              sat;
    } exp_t;
    exp_t q[$];
    exp_t mon_e;

    // Reference model state: frames actually written, fill level, sticky clip.
    logic [N*SW-1:0] wrote[$];
    int fill_m = 0;
    bit prev_m = 0;
    bit sat_m = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        wrote.delete();
        fill_m = 0;
        prev_m = 0;
        sat_m = 0;
    endtask

    task automatic model(input logic [N*SW-1:0] x, input logic [N*DW-1:0] dlv,
                         input logic [1:0] m, input bit e, output logic [N*SW-1:0] y);
        logic signed [SW-1:0] t;
        logic [DW-1:0] dd;
        logic [N*SW-1:0] old;
        int xs, wet, d, s;
        y = '0;
        if (e && !prev_m) fill_m = 0;
        prev_m = e;
        for (int k = 0; k < N; k++) begin
            t = x[k*SW +: SW];
            xs = t;
            dd = dlv[k*DW +: DW];
            d = dd;
            if (d > MD - 1) d = MD - 1;
            if (!e) begin
                s = xs;
            end else begin
                if (d == 0) wet = xs;
                else if (fill_m < d) wet = 0;
                else begin
                    old = wrote[wrote.size() - d];
                    t = old[k*SW +: SW];
                    wet = t;
                end
                if (m == 2'd1) begin
                    s = xs + wet;
                    if (s > 32767) begin s = 32767; sat_m = 1; end
                    else if (s < -32768) begin s = -32768; sat_m = 1; end
                end else if (m == 2'd2) s = xs;
                else s = wet;
            end
            y[k*SW +: SW] = s[SW-1:0];
        end
        if (e) begin
            wrote.push_back(x);
            if (wrote.size() > MD) void'(wrote.pop_front());
            if (fill_m < MD) fill_m++;
        end
    endtask

    // Issue one trigger; scramble the inputs afterwards to prove they were captured.
    task automatic send(input logic [N*SW-1:0] x, input logic [N*DW-1:0] dlv,
                        input logic [1:0] m, input bit e, input int gap);
        exp_t ex;
        @(negedge clk);
        ain = x; dl = dlv; mode = m; en = e; trig = 1'b1;
        model(x, dlv, m, e, ex.y);
        ex.tc = cyc;
        ex.sat = sat_m;
        q.push_back(ex);
        @(negedge clk);
        trig = 1'b0;
        ain = (N*SW)'({$urandom, $urandom});
        dl = (N*DW)'($urandom);
        mode = 2'($urandom);
        en = 1'($urandom);
        repeat (gap) @(negedge clk);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_audio_out"}, 64'(aout), 64'd0);
        chk({tag, "_valid"}, 64'(dv), 64'd0);
        chk({tag, "_busy"}, 64'(bsy), 64'd0);
        chk({tag, "_dropped"}, 64'(drp), 64'd0);
        chk({tag, "_saturated"}, 64'(sat), 64'd0);
    endtask

    function automatic logic [N*SW-1:0] rnd_x();
        return (N*SW)'({$urandom, $urandom});
    endfunction

    // Monitor: every valid pulse must match the oldest expected frame.
    always @(negedge clk) begin
        if (!rst && dv) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_valid: got valid with no frame pending (t=%0t)", $time);
            end else begin
                mon_e = q.pop_front();
                for (int k = 0; k < N; k++)
                    chk($sformatf("audio_out_ch%0d", k), 64'(aout[k*SW +: SW]),
                        64'(mon_e.y[k*SW +: SW]));
                chk("latency", 64'(cyc - mon_e.tc), 64'(LAT));
                chk("saturated", 64'(sat), 64'(mon_e.sat));
            end
        end
    end

    // Count cycles with trigger_dropped high.
    always @(negedge clk) begin
        if (!rst && drp) drop_cnt <= drop_cnt + 1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N*SW-1:0] x;
        logic [N*DW-1:0] d;
        // Reset state.
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);

        // Ch0 delay 4, wet only, ramp input on ch0.
        for (int i = 0; i < 8; i++) begin
            x = rnd_x();
            x[SW-1:0] = 16'(i + 1);
            send(x, {4'd0, 4'd0, 4'd4}, 2'd0, 1'b1, 10);
        end

        // Zero delay on every channel: output equals the same frame's input.
        for (int i = 0; i < 3; i++) send(rnd_x(), '0, 2'd0, 1'b1, 10 + int'($urandom_range(0, 2)));

        // Positive and negative clipping in dry+wet mode; flag stays set.
        send({16'h0123, 16'h9000, 16'h7000}, '0, 2'd1, 1'b1, 10);
        send(rnd_x(), '0, 2'd0, 1'b1, 10);
        send(rnd_x(), {4'd2, 4'd1, 4'd3}, 2'd2, 1'b1, 10);

        // Second trigger three cycles into a frame is dropped.
        @(negedge clk);
        ain = rnd_x(); dl = {4'd1, 4'd2, 4'd0}; mode = 2'd0; en = 1'b1; trig = 1'b1;
        begin
            exp_t ex;
            model(ain, dl, mode, en, ex.y);
            ex.tc = cyc;
            ex.sat = sat_m;
            q.push_back(ex);
        end
        @(negedge clk); trig = 1'b0;
        @(negedge clk);
        @(negedge clk); trig = 1'b1; ain = rnd_x();
        @(negedge clk); trig = 1'b0;
        repeat (12) @(negedge clk);
        chk("trigger_dropped_count", 64'(drop_cnt), 64'd1);

        // Reset while the frame sits in WAIT: no valid, all outputs cleared.
        @(negedge clk);
        ain = rnd_x(); dl = '0; mode = 2'd1; en = 1'b1; trig = 1'b1;
        @(negedge clk); trig = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        check_zero("midreset");
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("midreset_no_valid", 64'(dv), 64'd0);
        send(rnd_x(), '0, 2'd0, 1'b1, 10);

        // Maximum delay on all channels, well past two pointer wraps.
        for (int i = 0; i < 40; i++) send(rnd_x(), '1, 2'd0, 1'b1, 10);

        // Random frames: delays, modes, enable toggling.
        for (int i = 0; i < 60; i++) begin
            d = (N*DW)'($urandom);
            send(rnd_x(), d, 2'($urandom), ($urandom_range(0, 4) != 0),
                 10 + int'($urandom_range(0, 2)));
        end

        repeat (20) @(negedge clk);
        chk("queue_drained", 64'(q.size()), 64'd0);
        chk("trigger_dropped_final", 64'(drop_cnt), 64'd1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
